// File: rtl/float_to_int_ext.sv
// float_to_int_ext
//   Converts an IEEE-754 single-precision operand to an OUT_W-bit signed or
//   unsigned integer with selectable rounding. Overflow saturates and raises
//   invalid. Inexact is raised when the result is rounded.
//   The operand and result use a stb/ack handshake. A result is held in
//   put_z until it is accepted.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   input_a         IEEE-754 single-precision operand
//   input_rm        rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP
//   input_unsigned  1 = unsigned result, 0 = two's-complement result
//   input_a_stb     operand valid
//   input_a_ack     operand accept (registered)
//   output_z        integer result (registered)
//   output_flags    {invalid, inexact} (registered)
//   output_z_stb    result valid (registered)
//   output_z_ack    result accept
module float_to_int_ext #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_a,
  input  logic [1:0]       input_rm,
  input  logic             input_unsigned,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [OUT_W-1:0] output_z,
  output logic [1:0]       output_flags,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  localparam logic [OUT_W-1:0] SMAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   SMAX_M = {1'b0, SMAX};
  localparam logic [OUT_W:0]   SMIN_M = {1'b0, SMIN};
  localparam logic signed [9:0] E_MAX = 10'(OUT_W - 1);
  localparam logic signed [9:0] E_MIN = -10'sd1;

  typedef enum logic [2:0] {
    get_a, unpack, special_cases, align, round, put_z
  } state_t;

  state_t state, state_nxt;

  logic             ack_nxt, stb_nxt;
  logic [OUT_W-1:0] z_nxt;
  logic [1:0]       flags_nxt;

  // captured operand
  logic [31:0]      a_p0;
  logic [1:0]       rm_p0;
  logic             uns_p0;

  // unpacked fields
  logic             sign_p1;
  logic [7:0]       exp_p1;
  logic             frac_nz_p1;
  logic signed [9:0] e_p1;
  logic [23:0]      mant_p1;

  // aligned integer / guard / sticky
  logic [OUT_W-1:0] int_p2;
  logic             g_p2, s_p2;

  logic [OUT_W-1:0] int_c;
  logic             g_c, s_c;
  logic [9:0]       sh_amt;
  logic [OUT_W+23:0] sh;

  logic             inc_c;
  logic [OUT_W:0]   m_c;
  logic [OUT_W+1:0] res_c;

  // Round-increment decision from the rounding mode and the bits below the
  // binary point.
  function automatic logic rnd_inc(input logic [1:0] rm, input logic sign,
                                   input logic lsb, input logic g,
                                   input logic s);
    case (rm)
      2'd0:    return g & (s | lsb);
      2'd1:    return 1'b0;
      2'd2:    return sign & (g | s);
      default: return ~sign & (g | s);
    endcase
  endfunction

  // Range check of the rounded magnitude. Returns {z, invalid, inexact}.
  function automatic logic [OUT_W+1:0] sat_result(input logic [OUT_W:0] m,
                                                  input logic sign,
                                                  input logic uns,
                                                  input logic g,
                                                  input logic s);
    logic [OUT_W-1:0] z;
    logic             inv;
    z   = m[OUT_W-1:0];
    inv = 1'b0;
    if (uns) begin
      if (sign && (m != '0)) begin
        z   = '0;
        inv = 1'b1;
      end else if (m[OUT_W]) begin
        z   = '1;
        inv = 1'b1;
      end
    end else if (sign) begin
      if (m > SMIN_M) begin
        z   = SMIN;
        inv = 1'b1;
      end else begin
        z = '0 - m[OUT_W-1:0];
      end
    end else if (m > SMAX_M) begin
      z   = SMAX;
      inv = 1'b1;
    end
    return {z, inv, ~inv & (g | s)};
  endfunction

  // Saturation value for infinities and out-of-range finite operands.
  function automatic logic [OUT_W-1:0] sat_special(input logic sign,
                                                   input logic uns);
    if (sign) return uns ? '0 : SMIN;
    else      return uns ? '1 : SMAX;
  endfunction

  // Barrel shift: mant_p1 carries 23 fraction bits; shifting by e+1 leaves
  // 24 fraction bits, so bit 23 is the guard and bits 22:0 form the sticky.
  always_comb begin
    sh_amt = e_p1 + 10'sd1;
    sh     = {{OUT_W{1'b0}}, mant_p1} << sh_amt;
    if (e_p1 < E_MIN) begin
      int_c = '0;
      g_c   = 1'b0;
      s_c   = |mant_p1;
    end else begin
      int_c = sh[OUT_W+23:24];
      g_c   = sh[23];
      s_c   = |sh[22:0];
    end
  end

  always_comb begin
    inc_c = rnd_inc(rm_p0, sign_p1, int_p2[0], g_p2, s_p2);
    m_c   = {1'b0, int_p2} + (OUT_W+1)'(inc_c);
    res_c = sat_result(m_c, sign_p1, uns_p0, g_p2, s_p2);
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    stb_nxt   = output_z_stb;
    z_nxt     = output_z;
    flags_nxt = output_flags;
    case (state)
      get_a: begin
        ack_nxt = 1'b1;
        if (input_a_ack && input_a_stb) begin
          ack_nxt   = 1'b0;
          state_nxt = unpack;
        end
      end
      unpack: state_nxt = special_cases;
      special_cases: begin
        state_nxt = put_z;
        if (exp_p1 == 8'hFF) begin
          // NaN saturates high regardless of its sign bit
          z_nxt     = sat_special(sign_p1 & ~frac_nz_p1, uns_p0);
          flags_nxt = 2'b10;
        end else if ((exp_p1 == 8'h00) && !frac_nz_p1) begin
          z_nxt     = '0;
          flags_nxt = 2'b00;
        end else if (e_p1 > E_MAX) begin
          z_nxt     = sat_special(sign_p1, uns_p0);
          flags_nxt = 2'b10;
        end else begin
          state_nxt = align;
        end
      end
      align: state_nxt = round;
      round: begin
        z_nxt     = res_c[OUT_W+1:2];
        flags_nxt = res_c[1:0];
        state_nxt = put_z;
      end
      put_z: begin
        if (!output_z_stb) begin
          stb_nxt = 1'b1;
        end else if (output_z_ack) begin
          stb_nxt   = 1'b0;
          state_nxt = get_a;
        end
      end
      default: state_nxt = get_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= get_a;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      output_flags <= 2'b00;
    end else begin
      state        <= state_nxt;
      input_a_ack  <= ack_nxt;
      output_z_stb <= stb_nxt;
      output_z     <= z_nxt;
      output_flags <= flags_nxt;
    end
  end

  always_ff @(posedge clk) begin
    // p0: operand capture
    if (state == get_a && input_a_ack && input_a_stb) begin
      a_p0   <= input_a;
      rm_p0  <= input_rm;
      uns_p0 <= input_unsigned;
    end
    // p1: unpack
    if (state == unpack) begin
      sign_p1    <= a_p0[31];
      exp_p1     <= a_p0[30:23];
      frac_nz_p1 <= |a_p0[22:0];
      e_p1       <= $signed({2'b00, a_p0[30:23]}) - 10'sd127;
      mant_p1    <= {(a_p0[30:23] != 8'h00), a_p0[22:0]};
    end
    // p2: align
    if (state == align) begin
      int_p2 <= int_c;
      g_p2   <= g_c;
      s_p2   <= s_c;
    end
  end

endmodule

// File: tb/tb_float_to_int_ext.sv
// Testbench for float_to_int_ext (OUT_W = 32): directed vector table,
// randomized operands against an arithmetic reference model, and
// hand-written backpressure / ignored-ack / mid-operation reset sequences.
module tb_float_to_int_ext;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic [1:0]  input_rm;
  logic        input_unsigned;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic [1:0]  output_flags;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_vec = 0;
  int n_bad = 0;

  float_to_int_ext #(.OUT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_a        (input_a),
    .input_rm       (input_rm),
    .input_unsigned (input_unsigned),
    .input_a_stb    (input_a_stb),
    .input_a_ack    (input_a_ack),
    .output_z       (output_z),
    .output_flags   (output_flags),
    .output_z_stb   (output_z_stb),
    .output_z_ack   (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    logic        uns;
    logic [31:0] z;
    logic [1:0]  f;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: exact magnitude split into integer and remainder, rounded
  // and range-checked on the true numeric value.
  function automatic void ref_model(input logic [31:0] a, input logic [1:0] rm,
                                    input logic uns, output logic [31:0] z,
                                    output logic [1:0] f, output int lat);
    logic              sg;
    int                ex, e, sh;
    longint unsigned   one, fr, mant, mag, rem, half;
    logic              rem_nz, above, tie, up, inv;
    longint            v;
    one = 1;
    sg  = a[31];
    ex  = int'(a[30:23]);
    fr  = longint'(a[22:0]);
    if (ex == 255) begin
      lat = 3;
      f   = 2'b10;
      if (fr != 0 || !sg) z = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else                z = uns ? 32'h0 : 32'h8000_0000;
      return;
    end
    mant = (ex == 0) ? fr : (fr | (one << 23));
    e    = (ex == 0) ? -126 : ex - 127;
    lat  = ((ex == 0 && fr == 0) || (ex - 127 > 31)) ? 3 : 5;
    rem_nz = 1'b0; above = 1'b0; tie = 1'b0;
    if (e >= 23) begin
      mag = (e > 40) ? (one << 41) : (mant << (e - 23));
    end else if (e >= -37) begin
      sh     = 23 - e;
      mag    = mant >> sh;
      rem    = mant & ((one << sh) - 1);
      half   = one << (sh - 1);
      rem_nz = (rem != 0);
      above  = (rem > half);
      tie    = (rem == half);
    end else begin
      mag    = 0;
      rem_nz = (mant != 0);
    end
    case (rm)
      2'd0:    up = above || (tie && mag[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = sg && rem_nz;
      default: up = !sg && rem_nz;
    endcase
    mag = mag + (up ? one : 0);
    v   = sg ? -longint'(mag) : longint'(mag);
    inv = 1'b0;
    if (!uns) begin
      if (v < -64'sd2147483648)     begin z = 32'h8000_0000; inv = 1'b1; end
      else if (v > 64'sd2147483647) begin z = 32'h7FFF_FFFF; inv = 1'b1; end
      else z = v[31:0];
    end else begin
      if (v < 0)                    begin z = 32'h0;         inv = 1'b1; end
      else if (v > 64'sd4294967295) begin z = 32'hFFFF_FFFF; inv = 1'b1; end
      else z = v[31:0];
    end
    f = {inv, !inv && rem_nz};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [1:0] rm,
                          input logic uns, output logic ok);
    logic acc;
    input_a        = a;
    input_rm       = rm;
    input_unsigned = uns;
    input_a_stb    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = input_a_ack;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    input_a_stb = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_stb(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (output_z_stb) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!ok) check("stb_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check("stb_drop", 64'(output_z_stb), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [1:0] rm,
                        input logic uns, output logic [31:0] z,
                        output logic [1:0] f, output int lat);
    logic ok;
    z = '0; f = '0; lat = -1;
    start_op(a, rm, uns, ok);
    if (ok) begin
      wait_stb(lat, ok);
      z = output_z;
      f = output_flags;
      if (ok) drain();
    end
  endtask

  vec_t        tbl[20];
  logic [31:0] z, z0, ra, ez;
  logic [1:0]  f, f0, ef, rrm;
  logic        runs, ok;
  int          lat, elat, r;

  initial begin
    tbl[0]  = '{32'h4020_0000, 2'd0, 1'b0, 32'h0000_0002, 2'b01, 5};
    tbl[1]  = '{32'h4020_0000, 2'd3, 1'b0, 32'h0000_0003, 2'b01, 5};
    tbl[2]  = '{32'hC020_0000, 2'd2, 1'b0, 32'hFFFF_FFFD, 2'b01, 5};
    tbl[3]  = '{32'hC020_0000, 2'd1, 1'b0, 32'hFFFF_FFFE, 2'b01, 5};
    tbl[4]  = '{32'hCF00_0000, 2'd0, 1'b0, 32'h8000_0000, 2'b00, 5};
    tbl[5]  = '{32'h4F00_0000, 2'd0, 1'b0, 32'h7FFF_FFFF, 2'b10, 5};
    tbl[6]  = '{32'h4F00_0000, 2'd0, 1'b1, 32'h8000_0000, 2'b00, 5};
    tbl[7]  = '{32'h7FC0_0000, 2'd0, 1'b0, 32'h7FFF_FFFF, 2'b10, 3};
    tbl[8]  = '{32'h3F80_0000, 2'd0, 1'b0, 32'h0000_0001, 2'b00, 5};
    tbl[9]  = '{32'hBE80_0000, 2'd1, 1'b1, 32'h0000_0000, 2'b01, 5};
    tbl[10] = '{32'hBF80_0000, 2'd0, 1'b1, 32'h0000_0000, 2'b10, 5};
    tbl[11] = '{32'h0000_0001, 2'd3, 1'b0, 32'h0000_0001, 2'b01, 5};
    tbl[12] = '{32'hFF80_0000, 2'd0, 1'b0, 32'h8000_0000, 2'b10, 3};
    tbl[13] = '{32'h7F80_0000, 2'd0, 1'b1, 32'hFFFF_FFFF, 2'b10, 3};
    tbl[14] = '{32'h8000_0000, 2'd0, 1'b0, 32'h0000_0000, 2'b00, 3};
    tbl[15] = '{32'h4F80_0000, 2'd0, 1'b1, 32'hFFFF_FFFF, 2'b10, 3};
    tbl[16] = '{32'h3F00_0000, 2'd0, 1'b0, 32'h0000_0000, 2'b01, 5};
    tbl[17] = '{32'h3FC0_0000, 2'd0, 1'b0, 32'h0000_0002, 2'b01, 5};
    tbl[18] = '{32'h4F7F_FFFF, 2'd0, 1'b1, 32'hFFFF_FF00, 2'b00, 5};
    tbl[19] = '{32'hC120_0000, 2'd0, 1'b1, 32'h0000_0000, 2'b10, 5};

    rst = 1'b1;
    input_a = '0; input_rm = '0; input_unsigned = 1'b0;
    input_a_stb = 1'b0; output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",   64'(input_a_ack),  64'd0);
    check("reset_stb",   64'(output_z_stb), 64'd0);
    check("reset_z",     64'(output_z),     64'd0);
    check("reset_flags", 64'(output_flags), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(tbl[i].a, tbl[i].rm, tbl[i].uns, z, f, lat);
      check($sformatf("tbl%0d_z", i),     64'(z),   64'(tbl[i].z));
      check($sformatf("tbl%0d_flags", i), 64'(f),   64'(tbl[i].f));
      check($sformatf("tbl%0d_lat", i),   64'(lat), 64'(tbl[i].lat));
    end

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      ra[31]    = 1'($urandom_range(0, 1));
      ra[30:23] = (r == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(110, 160));
      ra[22:0]  = 23'($urandom);
      if (r == 1) ra[22:0] = ra[22:0] & 23'h7F_FF00;
      rrm  = 2'($urandom_range(0, 3));
      runs = 1'($urandom_range(0, 1));
      ref_model(ra, rrm, runs, ez, ef, elat);
      run_op(ra, rrm, runs, z, f, lat);
      check($sformatf("rnd_z a=%h rm=%0d u=%0d", ra, rrm, runs),     64'(z),   64'(ez));
      check($sformatf("rnd_flags a=%h rm=%0d u=%0d", ra, rrm, runs), 64'(f),   64'(ef));
      check($sformatf("rnd_lat a=%h", ra),                           64'(lat), 64'(elat));
    end

    // backpressure: result held, no new operand accepted
    start_op(32'h4020_0000, 2'd3, 1'b0, ok);
    wait_stb(lat, ok);
    z0 = output_z;
    f0 = output_flags;
    check("bp_z", 64'(z0), 64'h3);
    check("bp_flags", 64'(f0), 64'h1);
    input_a = 32'h3F80_0000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stb_hold",   64'(output_z_stb), 64'd1);
      check("bp_z_hold",     64'(output_z),     64'(z0));
      check("bp_flags_hold", 64'(output_flags), 64'(f0));
      check("bp_ack_low",    64'(input_a_ack),  64'd0);
    end
    input_a_stb = 1'b0;
    drain();

    // ack while no result pending is ignored
    output_z_ack = 1'b1;
    start_op(32'h3FC0_0000, 2'd0, 1'b0, ok);
    wait_stb(lat, ok);
    check("ign_lat", 64'(lat), 64'd5);
    check("ign_z", 64'(output_z), 64'd2);
    drain();

    // reset during align discards the operand
    start_op(32'h3F80_0000, 2'd0, 1'b0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ack", 64'(input_a_ack),  64'd0);
    check("mid_rst_stb", 64'(output_z_stb), 64'd0);
    check("mid_rst_z",   64'(output_z),     64'd0);
    @(posedge clk); #1;
    check("mid_rst_ack_back", 64'(input_a_ack), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_stb", 64'(output_z_stb), 64'd0);
    end
    run_op(32'hC020_0000, 2'd2, 1'b0, z, f, lat);
    check("post_rst_z", 64'(z), 64'hFFFF_FFFD);
    check("post_rst_lat", 64'(lat), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
